prog_loader: RTL

Boot-time program loader and instruction memory sitting directly upstream of the CPU's instruction port. It receives a program as a byte stream over a valid/ready handshake, assembles little-endian 16-bit words into an internal instruction RAM and holds the CPU in reset while loading. Once the program is complete it releases the CPU and serves `instr` for every `instrAddr` the CPU presents.

---
 rtl/loader_pkg.sv | 16 +
 rtl/instr_ram.sv | 25 ++
 rtl/prog_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LD_LO,
    LD_HI,
    RUN,
    ERR
  } loader_state_t;

  // Header is one 16-bit word count, sent low byte first.
  localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: synchronous write, asynchronous read, no reset on contents.
module instr_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Boot loader: assembles a byte stream into the instruction RAM, holds the
// CPU in reset while loading, then serves masked instruction fetches.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [15:0] instrAddr,
  output logic [15:0] instr,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_t state, state_next;

  logic [7:0]    n_lo;
  logic [15:0]   hdr_n;
  logic [7:0]    low;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   count;
  logic [15:0]   rdata;
  logic          we;
  logic          accept;
  logic          last_word;
  logic [15:0]   hdr_word;

  assign accept    = rx_valid && rx_ready;
  assign hdr_word  = {rx_data, n_lo};
  assign last_word = (16'(wr_ptr) == (hdr_n - 16'd1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HDR_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, ready and write-enable decode.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    we         = 1'b0;
    case (state)
      HDR_LO: begin
        rx_ready = 1'b1;
        if (accept) state_next = HDR_HI;
      end
      HDR_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (hdr_word == 16'd0)                state_next = RUN;
          else if ({1'b0, hdr_word} > DEPTH_W)  state_next = ERR;
          else                                  state_next = LD_LO;
        end
      end
      LD_LO: begin
        rx_ready = 1'b1;
        if (accept) state_next = LD_HI;
      end
      LD_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          we         = 1'b1;
          state_next = last_word ? RUN : LD_LO;
        end
      end
      RUN:     if (reload) state_next = HDR_LO;
      ERR:     if (reload) state_next = HDR_LO;
      default: state_next = HDR_LO;
    endcase
  end

  // Header capture, byte assembly, write pointer, visible count and CPU reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_lo      <= '0;
      hdr_n     <= '0;
      low       <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cpu_reset <= 1'b1;
    end else begin
      cpu_reset <= (state_next != RUN);
      if (state == HDR_LO && accept) n_lo <= rx_data;
      if (state == HDR_HI && accept) begin
        hdr_n  <= hdr_word;
        wr_ptr <= '0;
      end
      if (state == LD_LO && accept) low <= rx_data;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      // count is latched on RUN entry and forced to zero whenever not in RUN,
      // so stale RAM words are never visible to the CPU.
      if (state_next != RUN)  count <= '0;
      else if (state == LD_HI) count <= hdr_n;
      else if (state == HDR_HI) count <= '0;
    end
  end

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({rx_data, low}),
    .raddr (instrAddr[AW-1:0]),
    .rdata (rdata)
  );

  assign instr = (instrAddr < count) ? rdata : 16'h0000;
  assign done  = (state == RUN);
  assign err   = (state == ERR);

endmodule
